// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports and the DMEM port around the arbiter.
// The master modport is the requester/memory side, the slave modport is the arbiter.
interface dmem_port_arbiter_if #(
    parameter int AW = 32
);
    // Core load/store port
    logic          p0_req_i;
    logic [3:0]    p0_we_i;
    logic [AW-1:0] p0_addr_i;
    logic [31:0]   p0_wdata_i;
    logic          p0_gnt_o;
    logic          p0_rvalid_o;
    logic [31:0]   p0_rdata_o;

    // Debug / program loader port
    logic          p1_req_i;
    logic [3:0]    p1_we_i;
    logic [AW-1:0] p1_addr_i;
    logic [31:0]   p1_wdata_i;
    logic          p1_gnt_o;
    logic          p1_rvalid_o;
    logic [31:0]   p1_rdata_o;

    // Shared DMEM port (word addressed, 1-cycle synchronous read)
    logic          mem_en_o;
    logic [3:0]    mem_we_o;
    logic [AW-3:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    modport master (
        output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );

    modport slave (
        input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port DMEM arbiter: the core has fixed priority, the loader is protected
// from starvation by a saturating counter of consecutive core grants, and the
// read response is steered back to the port that owned the previous cycle.
module dmem_port_arbiter #(
    parameter int AW         = 32,
    parameter int MAX_CONSEC = 4
) (
    input logic                clk_i,
    input logic                rstn_i,
    dmem_port_arbiter_if.slave bus
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);

    logic       gnt0;
    logic       gnt1;
    logic       starved;
    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       owner_valid_q;
    logic       owner_valid_d;
    logic       owner_id_q;
    logic       owner_id_d;

    // Grant decision: core wins unless the loader has waited through MAX_CONSEC core grants
    always_comb begin
        starved = (starve_cnt_q == MAX_CNT);
        gnt1    = bus.p1_req_i & (~bus.p0_req_i | starved);
        gnt0    = bus.p0_req_i & ~gnt1;
    end

    // Memory request mux; all fields are forced to zero when nobody is granted
    always_comb begin
        bus.mem_en_o    = gnt0 | gnt1;
        bus.mem_we_o    = 4'b0000;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = 32'h0;
        if (gnt1) begin
            bus.mem_we_o    = bus.p1_we_i;
            bus.mem_addr_o  = bus.p1_addr_i[AW-1:2];
            bus.mem_wdata_o = bus.p1_wdata_i;
        end else if (gnt0) begin
            bus.mem_we_o    = bus.p0_we_i;
            bus.mem_addr_o  = bus.p0_addr_i[AW-1:2];
            bus.mem_wdata_o = bus.p0_wdata_i;
        end
        bus.p0_gnt_o = gnt0;
        bus.p1_gnt_o = gnt1;
    end

    // Next-state for the starvation counter and the response owner
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.p1_req_i || gnt1) begin
            starve_cnt_d = 4'd0;
        end else if (gnt0 && (starve_cnt_q < MAX_CNT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
        owner_valid_d = gnt0 | gnt1;
        owner_id_d    = gnt1;
    end

    // State registers; reset drops any response still in flight
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            starve_cnt_q  <= 4'd0;
            owner_valid_q <= 1'b0;
            owner_id_q    <= 1'b0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            owner_valid_q <= owner_valid_d;
            owner_id_q    <= owner_id_d;
        end
    end

    // Response steering: only the owning port sees the read data
    always_comb begin
        bus.p0_rvalid_o = owner_valid_q & ~owner_id_q;
        bus.p1_rvalid_o = owner_valid_q & owner_id_q;
        bus.p0_rdata_o  = bus.p0_rvalid_o ? bus.mem_rdata_i : 32'h0;
        bus.p1_rdata_o  = bus.p1_rvalid_o ? bus.mem_rdata_i : 32'h0;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter against a cycle-level
// model of the grant/starvation/response rules.
module tb_dmem_port_arbiter;

    localparam int AW         = 32;
    localparam int MAX_CONSEC = 4;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;

    int checks_total = 0;
    int checks_passed = 0;

    // Model state: length of the current core streak seen by a waiting loader,
    // and which port (-1 none) owns the response in the coming cycle.
    int streak = 0;
    int pend_owner = -1;

    dmem_port_arbiter_if #(.AW(AW)) bus ();

    dmem_port_arbiter #(.AW(AW), .MAX_CONSEC(MAX_CONSEC)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus.slave)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp)
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        else
            checks_passed++;
    endtask

    // Drive one cycle of requests plus the memory read data, check everything, advance the model
    task automatic applyStimulus(
        input logic p0r, input logic [3:0] p0w, input logic [31:0] p0a, input logic [31:0] p0d,
        input logic p1r, input logic [3:0] p1w, input logic [31:0] p1a, input logic [31:0] p1d,
        input logic [31:0] rd);
        int win;
        logic [3:0] e_we;
        logic [31:0] e_addr, e_wdata;
        @(negedge clk_i);
        bus.p0_req_i = p0r; bus.p0_we_i = p0w; bus.p0_addr_i = p0a; bus.p0_wdata_i = p0d;
        bus.p1_req_i = p1r; bus.p1_we_i = p1w; bus.p1_addr_i = p1a; bus.p1_wdata_i = p1d;
        bus.mem_rdata_i = rd;
        #1;
        if (p1r && (!p0r || streak >= MAX_CONSEC)) win = 1;
        else if (p0r) win = 0;
        else win = -1;
        e_we = 4'b0; e_addr = 32'h0; e_wdata = 32'h0;
        if (win == 0) begin e_we = p0w; e_addr = p0a / 4; e_wdata = p0d; end
        if (win == 1) begin e_we = p1w; e_addr = p1a / 4; e_wdata = p1d; end
        checkOutput("p0_gnt", 32'(bus.p0_gnt_o), 32'(win == 0));
        checkOutput("p1_gnt", 32'(bus.p1_gnt_o), 32'(win == 1));
        checkOutput("mem_en", 32'(bus.mem_en_o), 32'(win != -1));
        checkOutput("mem_we", 32'(bus.mem_we_o), 32'(e_we));
        checkOutput("mem_addr", 32'(bus.mem_addr_o), e_addr);
        checkOutput("mem_wdata", bus.mem_wdata_o, e_wdata);
        checkOutput("p0_rvalid", 32'(bus.p0_rvalid_o), 32'(pend_owner == 0));
        checkOutput("p1_rvalid", 32'(bus.p1_rvalid_o), 32'(pend_owner == 1));
        checkOutput("p0_rdata", bus.p0_rdata_o, (pend_owner == 0) ? rd : 32'h0);
        checkOutput("p1_rdata", bus.p1_rdata_o, (pend_owner == 1) ? rd : 32'h0);
        @(posedge clk_i);
        pend_owner = win;
        if (!p1r || win == 1) streak = 0;
        else if (win == 0 && streak < MAX_CONSEC) streak++;
    endtask

    task automatic idleCycle(input logic [31:0] rd);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, rd);
    endtask

    task automatic bothRead(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 4'h0, 32'h100 + 32'(4 * i), 32'h0,
                          1'b1, 4'h0, 32'h200 + 32'(4 * i), 32'h0, 32'h5000 + 32'(i));
    endtask

    // Sequential-only test flow
    initial begin
        bus.p0_req_i = 1'b0; bus.p0_we_i = 4'h0; bus.p0_addr_i = '0; bus.p0_wdata_i = '0;
        bus.p1_req_i = 1'b0; bus.p1_we_i = 4'h0; bus.p1_addr_i = '0; bus.p1_wdata_i = '0;
        bus.mem_rdata_i = 32'hFFFF_FFFF;

        // Reset state
        #12;
        checkOutput("rst_p0_rvalid", 32'(bus.p0_rvalid_o), 32'h0);
        checkOutput("rst_p1_rvalid", 32'(bus.p1_rvalid_o), 32'h0);
        checkOutput("rst_p0_rdata", bus.p0_rdata_o, 32'h0);
        checkOutput("rst_mem_en", 32'(bus.mem_en_o), 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Single core read at 0x10, memory answers DEADBEEF
        applyStimulus(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        idleCycle(32'hDEAD_BEEF);

        // Loader write alone
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0011, 32'h40, 32'h0000_1234, 32'h0);
        idleCycle(32'h1111_2222);

        // Contention: p0 x4, p1, p0 x4, p1, ...
        bothRead(12);
        idleCycle(32'h0);

        // Back-to-back reads on alternating ports
        applyStimulus(1'b1, 4'h0, 32'h20, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h24, 32'h0, 32'hA);
        idleCycle(32'hB);

        // Loader drops after 3 core grants: streak restarts
        bothRead(3);
        applyStimulus(1'b1, 4'h0, 32'h300, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h7);
        bothRead(6);
        idleCycle(32'h0);

        // Reset right after a core read grant discards its response
        bothRead(2);
        applyStimulus(1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        bus.p0_req_i = 1'b0; bus.p1_req_i = 1'b0;
        rstn_i = 1'b0;
        #1;
        checkOutput("midrst_p0_rvalid", 32'(bus.p0_rvalid_o), 32'h0);
        checkOutput("midrst_p0_rdata", bus.p0_rdata_o, 32'h0);
        pend_owner = -1;
        streak = 0;
        @(posedge clk_i);
        #1;
        checkOutput("midrst_hold_rvalid", 32'(bus.p0_rvalid_o), 32'h0);
        rstn_i = 1'b1;
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h44, 32'h0, 32'h0);
        idleCycle(32'hCAFE_0001);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom), $urandom, $urandom,
                          1'($urandom_range(0, 2) != 0), 4'($urandom), $urandom, $urandom,
                          $urandom);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
